// File: rtl/bcd_decrementor.sv
// Loadable NDIGITS-digit packed-BCD down-counter with zero, borrow and load-error flags.
// Optional build macro: BCD_DECR_SATURATE_EN (decrement at zero holds at 0 instead of wrapping).
module bcd_decrementor #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] load_data,
  input  logic                 decr,
  output logic [4*NDIGITS-1:0] data,
  output logic                 zero,
  output logic                 borrow,
  output logic                 load_err
);

  localparam int unsigned W = 4 * NDIGITS;

  logic [W-1:0] r_data;
  logic         r_zero;
  logic         r_borrow;
  logic         r_load_err;

  logic         w_load_ok;
  logic         w_is_zero;
  logic         w_ripple;
  logic [W-1:0] w_dec_data;
  logic [W-1:0] w_next_data;
  logic         w_next_borrow;
  logic         w_next_load_err;

  // Reject any load word carrying a digit above 9.
  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (load_data[4*i +: 4] > 4'd9) begin
        w_load_ok = 1'b0;
      end
    end
  end

  assign w_is_zero = (r_data == '0);

  // Single-cycle BCD decrement: trailing zero digits become 9 until the first non-zero digit.
  always_comb begin
    w_dec_data = r_data;
    w_ripple   = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_ripple) begin
        if (r_data[4*i +: 4] == 4'd0) begin
          w_dec_data[4*i +: 4] = 4'd9;
        end else begin
          w_dec_data[4*i +: 4] = r_data[4*i +: 4] - 4'd1;
          w_ripple             = 1'b0;
        end
      end
    end
  end

  // Next-state selection: load wins over decr; an all-zero decrement naturally wraps to all nines.
  always_comb begin
    w_next_data     = r_data;
    w_next_borrow   = 1'b0;
    w_next_load_err = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_next_data = load_data;
      end else begin
        w_next_load_err = 1'b1;
      end
    end else if (decr) begin
      if (w_is_zero) begin
        w_next_borrow = 1'b1;
`ifdef BCD_DECR_SATURATE_EN
        w_next_data   = '0;
`else
        w_next_data   = w_dec_data;
`endif
      end else begin
        w_next_data = w_dec_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_zero     <= 1'b1;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_data     <= w_next_data;
      r_zero     <= (w_next_data == '0);
      r_borrow   <= w_next_borrow;
      r_load_err <= w_next_load_err;
    end
  end

  assign data     = r_data;
  assign zero     = r_zero;
  assign borrow   = r_borrow;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_decrementor.sv
// Scoreboard bench for bcd_decrementor: integer reference model feeds an expected-value queue,
// an independent monitor compares every cycle's outputs.
module tb_bcd_decrementor;

  localparam int unsigned NDIGITS = 4;
  localparam int unsigned W       = 4 * NDIGITS;
  localparam int          MAXV    = 10 ** NDIGITS - 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic         zero;
    logic         borrow;
    logic         load_err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_data;
  logic         decr;
  logic [W-1:0] data;
  logic         zero;
  logic         borrow;
  logic         load_err;

  exp_t sb[$];
  int   model_val;
  int   n_checks;
  int   n_errors;

  bcd_decrementor #(.NDIGITS(NDIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .decr      (decr),
    .data      (data),
    .zero      (zero),
    .borrow    (borrow),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] b, output bit ok);
    int v;
    int d;
    v  = 0;
    ok = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) ok = 1'b0;
      v = v * 10 + d;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's expected post-edge outputs.
  task automatic step(input logic rst, input logic ld, input logic [W-1:0] ldd, input logic dc);
    exp_t e;
    bit   ok;
    int   v;
    @(negedge clk);
    reset     = rst;
    load      = ld;
    load_data = ldd;
    decr      = dc;
    e.borrow   = 1'b0;
    e.load_err = 1'b0;
    if (rst) begin
      model_val = 0;
    end else if (ld) begin
      v = bcd2int(ldd, ok);
      if (ok) model_val = v;
      else    e.load_err = 1'b1;
    end else if (dc) begin
      if (model_val == 0) begin
        e.borrow = 1'b1;
`ifndef BCD_DECR_SATURATE_EN
        model_val = MAXV;
`endif
      end else begin
        model_val = model_val - 1;
      end
    end
    e.data = int2bcd(model_val);
    e.zero = (model_val == 0);
    sb.push_back(e);
  endtask

  // Monitor: one DUT output word per cycle, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data",     data,         e.data);
        chk("zero",     W'(zero),     W'(e.zero));
        chk("borrow",   W'(borrow),   W'(e.borrow));
        chk("load_err", W'(load_err), W'(e.load_err));
      end
    end
  end

  initial begin
    logic [W-1:0] ldd;
    n_checks  = 0;
    n_errors  = 0;
    model_val = 0;
    reset     = 1'b1;
    load      = 1'b0;
    load_data = '0;
    decr      = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Ripple through 0100 -> 0099 -> ... -> 0000.
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // Underflow from zero, then let the pulse drop.
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // Rejected load keeps the held value.
    step(1'b0, 1'b1, 16'h0050, 1'b0);
    step(1'b0, 1'b1, 16'h12A4, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Load beats a simultaneous decr.
    step(1'b0, 1'b1, 16'h0007, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of a held decr.
    step(1'b0, 1'b1, 16'h1000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic, biased toward small values so underflow is exercised.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       ldd = W'($urandom);
        1:       ldd = int2bcd(int'($urandom_range(0, 3)));
        default: ldd = int2bcd(int'($urandom_range(0, MAXV)));
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, ldd, $urandom_range(0, 9) < 7);
    end
    step(1'b0, 1'b0, '0, 1'b0);

    @(posedge clk);
    #2;
    chk("sb_empty", W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
